// File: rtl/fft_np.sv
// Fully parallel N-point radix-2 DIT FFT. The butterfly network is combinational and the
// output is registered, so latency is one clock. Every stage scales its outputs by 1/2.
module fft_np #(
  parameter int N            = 4,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [N*SAMPLE_WIDTH-1:0] data_in,
  output logic [N*SAMPLE_WIDTH-1:0] data_out
);

  localparam int DATA_W = SAMPLE_WIDTH / 2;
  localparam int COEF_W = DATA_W;
  localparam int STAGES = $clog2(N);

  typedef logic signed [DATA_W-1:0] part_t;

  function automatic int bit_rev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < STAGES; b++) begin
      if (((v >> b) & 1) != 0) r = r | (1 << (STAGES - 1 - b));
    end
    return r;
  endfunction

  // Twiddle W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded half away from zero into Q1.(COEF_W-1).
  function automatic part_t tw_coef(input int k, input logic want_im);
    real ang;
    real v;
    int  r;
    int  lim;
    lim = (1 << (COEF_W - 1)) - 1;
    ang = 6.283185307179586 * real'(k) / real'(N);
    v   = want_im ? -$sin(ang) : $cos(ang);
    v   = v * real'(1 << (COEF_W - 1));
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    if (r > lim)  r = lim;
    if (r < -lim) r = -lim;
    return part_t'(r);
  endfunction

  function automatic part_t cmul_re(input part_t br, input part_t bi, input part_t wr, input part_t wi);
    logic signed [2*DATA_W:0] acc;
    acc = (2*DATA_W+1)'(br) * (2*DATA_W+1)'(wr) - (2*DATA_W+1)'(bi) * (2*DATA_W+1)'(wi);
    return acc[COEF_W-1 +: DATA_W];
  endfunction

  function automatic part_t cmul_im(input part_t br, input part_t bi, input part_t wr, input part_t wi);
    logic signed [2*DATA_W:0] acc;
    acc = (2*DATA_W+1)'(br) * (2*DATA_W+1)'(wi) + (2*DATA_W+1)'(bi) * (2*DATA_W+1)'(wr);
    return acc[COEF_W-1 +: DATA_W];
  endfunction

  // One-bit-growth add/subtract followed by an arithmetic halving (floor).
  function automatic part_t scale_add(input part_t a, input part_t b, input logic sub);
    logic signed [DATA_W:0] sum;
    sum = sub ? ({a[DATA_W-1], a} - {b[DATA_W-1], b}) : ({a[DATA_W-1], a} + {b[DATA_W-1], b});
    return sum[DATA_W:1];
  endfunction

  part_t re_s [STAGES+1][N];
  part_t im_s [STAGES+1][N];

  // Stage 0: bit-reversed unpacking of the input vector
  for (genvar k = 0; k < N; k++) begin : g_in
    localparam int SRC = bit_rev(k);
    assign re_s[0][k] = data_in[SRC*SAMPLE_WIDTH +: DATA_W];
    assign im_s[0][k] = data_in[SRC*SAMPLE_WIDTH + DATA_W +: DATA_W];
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int HALF = 1 << s;
    localparam int SPAN = 2 * HALF;
    for (genvar p = 0; p < N/2; p++) begin : g_bfly
      localparam int J   = p % HALF;
      localparam int TOP = (p / HALF) * SPAN + J;
      localparam int BOT = TOP + HALF;
      localparam int TW  = J * (N / SPAN);
      part_t wbr;
      part_t wbi;
      if (TW == 0) begin : g_w0
        assign wbr = re_s[s][BOT];
        assign wbi = im_s[s][BOT];
      end else if (4 * TW == N) begin : g_wnj
        assign wbr = im_s[s][BOT];
        assign wbi = -re_s[s][BOT];
      end else begin : g_wgen
        localparam part_t WR = tw_coef(TW, 1'b0);
        localparam part_t WI = tw_coef(TW, 1'b1);
        assign wbr = cmul_re(re_s[s][BOT], im_s[s][BOT], WR, WI);
        assign wbi = cmul_im(re_s[s][BOT], im_s[s][BOT], WR, WI);
      end
      assign re_s[s+1][TOP] = scale_add(re_s[s][TOP], wbr, 1'b0);
      assign im_s[s+1][TOP] = scale_add(im_s[s][TOP], wbi, 1'b0);
      assign re_s[s+1][BOT] = scale_add(re_s[s][TOP], wbr, 1'b1);
      assign im_s[s+1][BOT] = scale_add(im_s[s][TOP], wbi, 1'b1);
    end
  end

  // Stage p1: output register, natural bin order
  logic [N*SAMPLE_WIDTH-1:0] spec_p1_d;
  logic [N*SAMPLE_WIDTH-1:0] spec_p1_q;

  always_comb begin
    spec_p1_d = '0;
    for (int k = 0; k < N; k++) begin
      spec_p1_d[k*SAMPLE_WIDTH +: DATA_W]          = re_s[STAGES][k];
      spec_p1_d[k*SAMPLE_WIDTH + DATA_W +: DATA_W] = im_s[STAGES][k];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) spec_p1_q <= '0;
    else         spec_p1_q <= spec_p1_d;
  end

  assign data_out = spec_p1_q;

endmodule

// File: tb/tb_fft_np.sv
// Bench for fft_np: N=4 directed and randomized vectors against a closed-form reference,
// asynchronous reset behaviour, and an N=8 impulse exercising the general twiddle path.
module tb_fft_np;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [4*SW-1:0] din4 = '0;
  logic [4*SW-1:0] dout4;
  logic [8*SW-1:0] din8 = '0;
  logic [8*SW-1:0] dout8;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_np #(.N(4), .SAMPLE_WIDTH(SW)) u_dut4 (
    .clk(clk), .arst_n(arst_n), .data_in(din4), .data_out(dout4));
  fft_np #(.N(8), .SAMPLE_WIDTH(SW)) u_dut8 (
    .clk(clk), .arst_n(arst_n), .data_in(din8), .data_out(dout8));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  function automatic int h(input int v);
    return wrap8(v >>> 1);
  endfunction

  function automatic int part(input logic [8*SW-1:0] v, input int k, input bit im);
    logic signed [7:0] t;
    t = v[k*SW + (im ? 8 : 0) +: 8];
    return int'(t);
  endfunction

  function automatic logic [8*SW-1:0] pack(input int r[8], input int i[8]);
    logic [8*SW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[k*SW +: 8]     = 8'(r[k]);
      v[k*SW + 8 +: 8] = 8'(i[k]);
    end
    return v;
  endfunction

  // Closed-form 4-point transform: even/odd half-size DFTs, then combine with W^0 and -j.
  function automatic logic [8*SW-1:0] ref4(input logic [8*SW-1:0] x);
    int xr[4], xi[4];
    int er[2], ei[2], odr[2], odi[2];
    int yr[8], yi[8];
    int rr, ri;
    for (int k = 0; k < 4; k++) begin
      xr[k] = part(x, k, 1'b0);
      xi[k] = part(x, k, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      yr[k] = 0;
      yi[k] = 0;
    end
    er[0]  = h(xr[0] + xr[2]); ei[0]  = h(xi[0] + xi[2]);
    er[1]  = h(xr[0] - xr[2]); ei[1]  = h(xi[0] - xi[2]);
    odr[0] = h(xr[1] + xr[3]); odi[0] = h(xi[1] + xi[3]);
    odr[1] = h(xr[1] - xr[3]); odi[1] = h(xi[1] - xi[3]);
    yr[0] = h(er[0] + odr[0]); yi[0] = h(ei[0] + odi[0]);
    yr[2] = h(er[0] - odr[0]); yi[2] = h(ei[0] - odi[0]);
    rr = odi[1];
    ri = wrap8(-odr[1]);
    yr[1] = h(er[1] + rr); yi[1] = h(ei[1] + ri);
    yr[3] = h(er[1] - rr); yi[3] = h(ei[1] - ri);
    return pack(yr, yi);
  endfunction

  task automatic cmp_vec(input string tag, input logic [8*SW-1:0] obs,
                         input logic [8*SW-1:0] want, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s[%0d].re", tag, k), part(obs, k, 1'b0), part(want, k, 1'b0));
      chk($sformatf("%s[%0d].im", tag, k), part(obs, k, 1'b1), part(want, k, 1'b1));
    end
  endtask

  task automatic apply_chk4(input string tag, input logic [8*SW-1:0] x, input logic [8*SW-1:0] want);
    @(negedge clk);
    din4 = x[4*SW-1:0];
    @(negedge clk);
    cmp_vec(tag, 128'(dout4), want, 4);
  endtask

  logic [8*SW-1:0] x, exp_v;

  initial begin
    din4 = 64'h7f01_80ff_1234_5678;
    din8 = {2{64'h55aa_33cc_0f0f_7e81}};
    repeat (2) @(negedge clk);
    cmp_vec("reset4", 128'(dout4), '0, 4);
    cmp_vec("reset8", dout8, '0, 8);
    arst_n = 1'b1;

    apply_chk4("ramp", pack('{16, 32, 48, 64, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}),
                       pack('{40, -8, -8, -8, 0, 0, 0, 0}, '{0, 8, 0, -8, 0, 0, 0, 0}));
    apply_chk4("impulse", pack('{64, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}),
                          pack('{16, 16, 16, 16, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}));
    apply_chk4("dc", pack('{32, 32, 32, 32, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}),
                     pack('{32, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}));
    apply_chk4("alt", pack('{64, -64, 64, -64, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}),
                      pack('{0, 0, 64, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}));
    apply_chk4("imag_ramp", pack('{0, 0, 0, 0, 0, 0, 0, 0}, '{16, 32, 48, 64, 0, 0, 0, 0}),
                            pack('{0, -8, 0, 8, 0, 0, 0, 0}, '{40, -8, -8, -8, 0, 0, 0, 0}));

    // Back-to-back random vectors, each checked one cycle after it is applied.
    exp_v = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i > 0) cmp_vec("rand", 128'(dout4), exp_v, 4);
      x = {64'h0, $urandom, $urandom};
      din4 = x[4*SW-1:0];
      exp_v = ref4(x);
    end
    @(negedge clk);
    cmp_vec("rand_last", 128'(dout4), exp_v, 4);

    // Asynchronous reset mid-stream, then resume.
    x = {64'h0, 32'h4020_10f0, 32'h7f80_c033};
    din4 = x[4*SW-1:0];
    exp_v = ref4(x);
    @(negedge clk);
    cmp_vec("pre_rst", 128'(dout4), exp_v, 4);
    #2 arst_n = 1'b0;
    #1 cmp_vec("arst_async", 128'(dout4), '0, 4);
    @(negedge clk);
    cmp_vec("arst_hold", 128'(dout4), '0, 4);
    arst_n = 1'b1;
    x = {64'h0, $urandom, $urandom};
    din4 = x[4*SW-1:0];
    exp_v = ref4(x);
    @(negedge clk);
    cmp_vec("resume", 128'(dout4), exp_v, 4);

    // N=8 impulse at x1 = (64,0): X[k] = 8*W^k with Q1.7 twiddles.
    @(negedge clk);
    din8 = pack('{0, 64, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    cmp_vec("n8_impulse", dout8,
            pack('{8, 5, 0, -6, -8, -6, 0, 6}, '{0, -6, -8, -6, 0, 6, 8, 6}), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
